// File: rtl/snake_pkg.sv
// Shared types and constants for the snake IR remote front end.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    CMD_IGNORE = 2'd0,
    CMD_MOVE   = 2'd1,
    CMD_START  = 2'd2
  } cmd_kind_t;

  localparam logic [7:0] NEC_ADDR       = 8'h20;
  localparam logic [7:0] NEC_CODE_UP    = 8'h02;
  localparam logic [7:0] NEC_CODE_DOWN  = 8'h82;
  localparam logic [7:0] NEC_CODE_LEFT  = 8'hE0;
  localparam logic [7:0] NEC_CODE_RIGHT = 8'h60;
  localparam logic [7:0] NEC_CODE_OK    = 8'h22;

  function automatic dir_t dir_opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Two-entry direction queue; a pop and a push may share a cycle even when full.
module dir_fifo
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  dir_t din,
  input  logic pop,
  output dir_t dout,
  output dir_t tail,
  output logic empty,
  output logic full
);

  logic [1:0] r_count;
  dir_t       r_mem0;
  dir_t       r_mem1;
  logic       w_pop;
  logic       w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_mem0  <= RIGHT;
      r_mem1  <= RIGHT;
    end else begin
      case ({w_pop, w_push})
        2'b10: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd0) r_mem0 <= din;
          else                 r_mem1 <= din;
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever survives the pop.
          if (r_count == 2'd1) begin
            r_mem0 <= din;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_mem0;
  assign tail  = (r_count == 2'd2) ? r_mem1 : r_mem0;
  assign empty = (r_count == 2'd0);
  assign full  = (r_count == 2'd2);

endmodule

// File: rtl/ir_cmd_decoder.sv
// NEC remote frame decoder: two-stage validate/classify pipeline feeding a
// direction queue that is drained into dir on each game tick.
module ir_cmd_decoder
  import snake_pkg::*;
#(
  parameter logic [7:0] ADDR       = NEC_ADDR,
  parameter logic [7:0] CODE_UP    = NEC_CODE_UP,
  parameter logic [7:0] CODE_DOWN  = NEC_CODE_DOWN,
  parameter logic [7:0] CODE_LEFT  = NEC_CODE_LEFT,
  parameter logic [7:0] CODE_RIGHT = NEC_CODE_RIGHT,
  parameter logic [7:0] CODE_OK    = NEC_CODE_OK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word,
  input  logic        word_valid,
  input  logic        game_tick,
  output dir_t        dir,
  output logic        dir_changed,
  output logic        start_pulse,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  logic        r_s1_valid;
  logic [31:0] r_s1_word;
  dir_t        r_dir;
  logic        r_dir_changed;
  logic        r_start;
  logic        r_err;
  logic [7:0]  r_err_count;

  logic [7:0]  w_naddr;
  logic [7:0]  w_cmd;
  logic [7:0]  w_ncmd;
  logic        w_frame_ok;
  logic        w_frame_bad;
  cmd_kind_t   w_kind;
  dir_t        w_cand;
  dir_t        w_ref;
  logic        w_push;
  logic        w_pop;
  dir_t        w_fifo_dout;
  dir_t        w_fifo_tail;
  logic        w_fifo_empty;
  logic        w_fifo_full;

  assign w_naddr     = ~ADDR;
  assign w_cmd       = r_s1_word[15:8];
  assign w_ncmd      = ~r_s1_word[7:0];
  assign w_frame_ok  = r_s1_valid && (r_s1_word[31:24] == ADDR) &&
                       (r_s1_word[23:16] == w_naddr) && (w_cmd == w_ncmd);
  assign w_frame_bad = r_s1_valid && !w_frame_ok;

  always_comb begin
    w_kind = CMD_IGNORE;
    w_cand = UP;
    if (w_cmd == CODE_UP) begin
      w_kind = CMD_MOVE;
      w_cand = UP;
    end else if (w_cmd == CODE_DOWN) begin
      w_kind = CMD_MOVE;
      w_cand = DOWN;
    end else if (w_cmd == CODE_LEFT) begin
      w_kind = CMD_MOVE;
      w_cand = LEFT;
    end else if (w_cmd == CODE_RIGHT) begin
      w_kind = CMD_MOVE;
      w_cand = RIGHT;
    end else if (w_cmd == CODE_OK) begin
      w_kind = CMD_START;
    end
  end

  // When popping, the post-pop reference is the current tail if two entries
  // were queued, or the popped head (== tail) otherwise, so one mux suffices.
  assign w_ref  = w_fifo_empty ? r_dir : w_fifo_tail;
  assign w_pop  = game_tick && !w_fifo_empty;
  assign w_push = w_frame_ok && (w_kind == CMD_MOVE) &&
                  (w_cand != w_ref) && (w_cand != dir_opposite(w_ref));

  dir_fifo u_dir_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_cand),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .tail  (w_fifo_tail),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_word     <= '0;
      r_dir         <= RIGHT;
      r_dir_changed <= 1'b0;
      r_start       <= 1'b0;
      r_err         <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_s1_valid <= word_valid;
      if (word_valid) r_s1_word <= word;
      r_dir_changed <= w_pop;
      if (w_pop) r_dir <= w_fifo_dout;
      r_start <= w_frame_ok && (w_kind == CMD_START);
      r_err   <= w_frame_bad;
      if (w_frame_bad && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign dir         = r_dir;
  assign dir_changed = r_dir_changed;
  assign start_pulse = r_start;
  assign frame_err   = r_err;
  assign err_count   = r_err_count;

  logic w_unused;
  assign w_unused = w_fifo_full;

endmodule

// File: doc/ir_cmd_decoder.md
IR_CMD_DECODER -- requirements
Module: ir_cmd_decoder

Interface
REQ-001 Parameter ADDR, default 8'h20, is the NEC address byte accepted from the remote.
REQ-002 Parameters CODE_UP / CODE_DOWN / CODE_LEFT / CODE_RIGHT / CODE_OK, defaults 8'h02 / 8'h82 / 8'hE0 / 8'h60 / 8'h22, are the accepted command bytes.
REQ-003 clk  in  1  system clock; one clock domain; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 word  in  32  NEC frame from the IR receiver: [31:24] address, [23:16] ~address, [15:8] command, [7:0] ~command.
REQ-006 word_valid  in  1  one-cycle strobe; word is valid in that cycle.
REQ-007 game_tick  in  1  one-cycle strobe marking a snake step.
REQ-008 dir  out  2  committed direction, type dir_t (UP=0, DOWN=1, LEFT=2, RIGHT=3); stable between ticks.
REQ-009 dir_changed  out  1  one-cycle pulse in the cycle after dir is updated.
REQ-010 start_pulse  out  1  one-cycle pulse for an accepted OK command.
REQ-011 frame_err  out  1  one-cycle pulse for a rejected frame.
REQ-012 err_count  out  8  count of rejected frames; saturates at 8'hFF.

Function
REQ-013 Decoding is a two-stage pipeline: stage 1 registers word on word_valid; stage 2 validates and classifies the frame.
REQ-014 A frame is valid only when [31:24]==ADDR, [23:16]==~ADDR, and [7:0]==~[15:8].
REQ-015 A valid frame with a command byte not in the CODE set is treated as ignored: it is neither an error nor an action.
REQ-016 Each invalid frame raises frame_err and increments err_count (unless it is 8'hFF) exactly 2 cycles after word_valid.
REQ-017 A valid OK frame raises start_pulse exactly 2 cycles after word_valid.
REQ-018 A valid direction frame is a candidate, compared against the reference direction: the FIFO tail if the FIFO is non-empty, otherwise dir.
REQ-019 A candidate that is the opposite of the reference (UP/DOWN, LEFT/RIGHT) is dropped silently.
REQ-020 A candidate equal to the reference is dropped silently.
REQ-021 Any other candidate is pushed into a 2-entry FIFO in stage 2.
REQ-022 A push when the FIFO is full is dropped; FIFO contents are unchanged.
REQ-023 On game_tick with the FIFO non-empty: pop the head into dir, and pulse dir_changed in the next cycle.
REQ-024 On game_tick with the FIFO empty: dir holds and dir_changed stays low.
REQ-025 When game_tick and a stage-2 push occur in the same cycle, the pop happens first.
REQ-026 In that same-cycle case, the reference for REQ-018 is the post-pop tail, or the new dir if the FIFO becomes empty; the push then succeeds even if the FIFO was full before the pop.
REQ-027 A back-to-back word_valid on consecutive cycles is fully pipelined; no frame is lost.
REQ-028 Pipeline occupancy has no effect on the FIFO or on dir except through stage 2.

Reset
REQ-029 While reset is high: dir=RIGHT, FIFO empty, pipeline valid bits cleared, dir_changed=0, start_pulse=0, frame_err=0, err_count=0.
REQ-030 Frames in flight when reset asserts are discarded; the first frame accepted is one whose word_valid occurs in the cycle after reset deasserts.

Structure
REQ-031 The dir_t enum, the opposite-direction function and the default NEC code constants live in shared package snake_pkg.
REQ-032 The 2-entry FIFO is sub-module dir_fifo, with ports clk, reset, push, din, pop, dout, tail, empty, full.
REQ-033 No other sub-modules are used; the block must not contain a latch.

Verification
REQ-034 After reset, word=32'h20DF02FD strobed, then one game_tick -> dir=UP; dir_changed pulses once.
REQ-035 dir=RIGHT, word=32'h20DFE01F (LEFT) -> no push; a following tick leaves dir=RIGHT and err_count=0.
REQ-036 UP, then LEFT, then DOWN strobed before any tick -> FIFO holds UP,LEFT; DOWN dropped; two ticks give dir=UP, then dir=LEFT.
REQ-037 word=32'h20DF22DD -> start_pulse exactly 2 cycles after word_valid; word=32'h21DF02FD -> frame_err and err_count=1.
REQ-038 FIFO full (UP,LEFT) and a DOWN push coinciding with game_tick -> dir=UP; FIFO holds LEFT,DOWN.
REQ-039 300 bad frames -> err_count=8'hFF; reset mid-frame -> all outputs at their REQ-029 values in the next cycle.
